// File: rtl/uart_fifo.sv
// uart_fifo: UART transmitter plus a receiver that feeds a first-word-fall-through RX FIFO.
module uart_fifo #(
  parameter int unsigned CLKS_PER_BIT = 694,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Start,
  input  logic [DATA_BITS-1:0]          i_Data,
  output logic                          o_TX,
  output logic                          o_Busy,
  input  logic                          i_RX,
  output logic                          o_RX_Valid,
  input  logic                          i_RX_Read,
  output logic [DATA_BITS-1:0]          o_Data,
  output logic [$clog2(FIFO_DEPTH):0]   o_RX_Count,
  output logic                          o_Frame_Err,
  output logic                          o_Parity_Err,
  output logic                          o_Overrun,
  output logic                          o_Sample_Point
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW   = $clog2(DATA_BITS);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = AW + 1;

  localparam logic [CW-1:0]   BitLast  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]   DataLast = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]   StopLast = BW'(STOP_BITS - 1);
  localparam logic [CntW-1:0] Full     = CntW'(FIFO_DEPTH);

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_tick;

  assign tx_tick = (tx_cnt_q == BitLast);

  // TX next state: every non-idle state lasts whole bit periods; o_TX is registered
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    if (tx_state_q != TxIdle) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
    unique case (tx_state_q)
      TxIdle: begin
        tx_d = 1'b1;
        if (i_Start) begin
          tx_state_d = TxStart;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          tx_shift_d = i_Data;
          tx_par_d   = (PARITY == 1) ? ~(^i_Data) : ^i_Data;
        end
      end
      TxStart: begin
        if (tx_tick) begin
          tx_state_d = TxData;
          tx_idx_d   = '0;
          tx_d       = tx_shift_q[0];
        end
      end
      TxData: begin
        if (tx_tick) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_idx_q == DataLast) begin
            tx_idx_d = '0;
            if (PARITY != 0) begin
              tx_state_d = TxParity;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = TxStop;
              tx_d       = 1'b1;
            end
          end else begin
            tx_idx_d = tx_idx_q + BW'(1);
            tx_d     = tx_shift_q[1];
          end
        end
      end
      TxParity: begin
        if (tx_tick) begin
          tx_state_d = TxStop;
          tx_idx_d   = '0;
          tx_d       = 1'b1;
        end
      end
      TxStop: begin
        if (tx_tick) begin
          if (tx_idx_q == StopLast) tx_state_d = TxIdle;
          else                      tx_idx_d   = tx_idx_q + BW'(1);
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // TX state registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign o_TX   = tx_q;
  assign o_Busy = (tx_state_q != TxIdle);

  // ---------------------------------------------------------------- RX
  // RxWait holds off re-arming after a framing error until the line returns high.
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWait} rx_state_e;

  logic                 sync1_q, sync2_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 samp_q, samp_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 good_q, good_d;
  logic                 wr_q;
  logic                 rx_ones, par_bad;

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_RX;
      sync2_q <= sync1_q;
    end
  end

  assign rx_ones = ^{rx_shift_q, rx_par_q};
  assign par_bad = (PARITY == 1) ? ~rx_ones : (PARITY == 2) ? rx_ones : 1'b0;

  // RX next state: half-bit start sample, then one sample per bit period
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    samp_d     = 1'b0;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    good_d     = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (!sync2_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          samp_d     = 1'b1;
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = sync2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          samp_d     = 1'b1;
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == DataLast) rx_state_d = (PARITY != 0) ? RxParity : RxStop;
          else                      rx_idx_d   = rx_idx_q + BW'(1);
        end
      end
      RxParity: begin
        if (rx_cnt_q == BitLast) begin
          samp_d     = 1'b1;
          rx_cnt_d   = '0;
          rx_par_d   = sync2_q;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          samp_d   = 1'b1;
          rx_cnt_d = '0;
          if (!sync2_q) begin
            ferr_d     = 1'b1;
            rx_state_d = RxWait;
          end else begin
            perr_d     = par_bad;
            good_d     = ~par_bad;
            rx_state_d = RxIdle;
          end
        end
      end
      RxWait: begin
        rx_cnt_d = '0;
        if (sync2_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // RX state and pulse registers; wr_q issues the FIFO write one cycle after the stop sample
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      samp_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      good_q     <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      samp_q     <= samp_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      good_q     <= good_d;
      wr_q       <= good_q;
    end
  end

  assign o_Sample_Point = samp_q;
  assign o_Frame_Err    = ferr_q;
  assign o_Parity_Err   = perr_q;

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;
  logic                 rd_ok, wr_ok;

  // A write into a full FIFO still succeeds when the head is popped in the same cycle
  always_comb begin
    rd_ok    = i_RX_Read & (cnt_q != '0);
    wr_ok    = wr_q & ((cnt_q != Full) | rd_ok);
    ovr_d    = wr_q & (cnt_q == Full) & ~rd_ok;
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers, occupancy and overrun pulse
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
    end
  end

  // Storage array; contents are only visible through the occupancy-gated head
  always_ff @(posedge i_Clock) begin
    if (wr_ok) fifo_mem[wr_ptr_q] <= rx_shift_q;
  end

  assign o_RX_Valid = (cnt_q != '0);
  assign o_RX_Count = cnt_q;
  assign o_Data     = o_RX_Valid ? fifo_mem[rd_ptr_q] : '0;
  assign o_Overrun  = ovr_q;

endmodule
